// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - size/state encodings and lane helpers for mem_access_unit
package mem_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_ERR    = 2'd3;

    // Little-endian lane mask; callers truncate to their bus width.
    function automatic logic [63:0] byte_enable(input logic [1:0] size, input logic [5:0] offset);
        case (size)
            SZ_BYTE: byte_enable = 64'h1 << offset;
            SZ_HALF: byte_enable = 64'h3 << offset;
            SZ_WORD: byte_enable = 64'hF << offset;
            default: byte_enable = 64'h0;
        endcase
    endfunction

    // False for misaligned accesses and for the illegal size code.
    function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: addr_aligned = 1'b1;
            SZ_HALF: addr_aligned = ~lo[0];
            SZ_WORD: addr_aligned = (lo == 2'b00);
            default: addr_aligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - control-unit and memory-port signals of mem_access_unit
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  req;
    logic                  rw;
    logic [1:0]            size;
    logic                  sign_ext;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  busy;
    logic                  moc;
    logic                  err;
    logic [DATA_W-1:0]     rdata;
    logic                  mem_en;
    logic                  mem_rw;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ready;

    // Environment side: control unit plus memory.
    modport master (
        output req, rw, size, sign_ext, addr, wdata, mem_rdata, mem_ready,
        input  busy, moc, err, rdata, mem_en, mem_rw, mem_addr, mem_be, mem_wdata
    );

    // Access-unit side.
    modport slave (
        input  req, rw, size, sign_ext, addr, wdata, mem_rdata, mem_ready,
        output busy, moc, err, rdata, mem_en, mem_rw, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store-data lane replication and load steering/extension
module mem_lane_align
    import mem_if_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB    = DATA_W / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [OFF_W-1:0]  offset_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [DATA_W-1:0] load_data_o
);

    int                unit_b;
    int                width;
    int                off;
    logic [DATA_W-1:0] shifted;

    // Replicate the right-justified store unit across all lanes; shift the
    // addressed unit of read data down to bit 0 and extend it to full width.
    always_comb begin
        case (size_i)
            SZ_BYTE: unit_b = 1;
            SZ_HALF: unit_b = 2;
            default: unit_b = (NB < 4) ? NB : 4;
        endcase
        width   = unit_b * 8;
        off     = int'(offset_i) - (int'(offset_i) % unit_b);
        shifted = mem_rdata_i >> (off * 8);
        for (int i = 0; i < DATA_W; i++) begin
            load_data_o[i] = (i < width) ? shifted[i] : (sign_ext_i & shifted[width-1]);
        end
        for (int k = 0; k < NB; k++) begin
            mem_wdata_o[k*8 +: 8] = wdata_i[(k % unit_b)*8 +: 8];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multicycle MAR/MDR memory-access unit; optional MEM_IF_TIMEOUT_EN
module mem_access_unit
    import mem_if_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    mem_access_unit_if.slave bus
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] wdr_q;
    logic [DATA_W-1:0] mdr_q;
    logic              rw_q;
    logic [1:0]        size_q;
    logic              sext_q;
    logic              accept;
    logic              req_ok;
    logic              timeout_hit;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] lane_wdata;

    assign accept = bus.req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign req_ok = addr_aligned(bus.size, bus.addr[1:0]);

`ifdef MEM_IF_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;

    // Count cycles spent in ACCESS; held at zero elsewhere so it restarts on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (state_q != ST_ACCESS) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    // Next state; mem_ready takes priority over an expiring timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) state_d = req_ok ? ST_ACCESS : ST_ERR;
                else        state_d = ST_IDLE;
            end
            ST_ACCESS: begin
                if (bus.mem_ready)    state_d = ST_DONE;
                else if (timeout_hit) state_d = ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State plus MAR/MDR: request fields latch on accept, MDR only on a completed read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mar_q   <= '0;
            wdr_q   <= '0;
            mdr_q   <= '0;
            rw_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sext_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mar_q  <= bus.addr;
                wdr_q  <= bus.wdata;
                rw_q   <= bus.rw;
                size_q <= bus.size;
                sext_q <= bus.sign_ext;
            end
            if ((state_q == ST_ACCESS) && bus.mem_ready && rw_q) begin
                mdr_q <= load_data;
            end
        end
    end

    mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .size_i      (size_q),
        .sign_ext_i  (sext_q),
        .offset_i    (mar_q[OFF_W-1:0]),
        .wdata_i     (wdr_q),
        .mem_rdata_i (bus.mem_rdata),
        .mem_wdata_o (lane_wdata),
        .load_data_o (load_data)
    );

    assign bus.busy      = (state_q == ST_ACCESS) || (state_q == ST_ERR);
    assign bus.moc       = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign bus.err       = (state_q == ST_ERR);
    assign bus.rdata     = mdr_q;
    assign bus.mem_en    = (state_q == ST_ACCESS);
    assign bus.mem_rw    = rw_q;
    assign bus.mem_addr  = {mar_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign bus.mem_be    = (state_q == ST_ACCESS) ? NB'(byte_enable(size_q, 6'(mar_q[OFF_W-1:0]))) : '0;
    assign bus.mem_wdata = lane_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
    import mem_if_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic rw, input logic [1:0] size, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req      = 1'b1;
        bus.rw       = rw;
        bus.size     = size;
        bus.sign_ext = sext;
        bus.addr     = addr;
        bus.wdata    = wdata;
    endtask

    task automatic test_reset;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        checks++; if (bus.moc !== 1'b0) begin errors++; $display("FAIL rst_moc got %b exp 0", bus.moc); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.err); end
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en got %b exp 0", bus.mem_en); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
        checks++; if (bus.mem_be !== 4'h0) begin errors++; $display("FAIL rst_mem_be got %b exp 0000", bus.mem_be); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", bus.mem_addr); end
        step;
        reset = 1'b1;
        step;
    endtask

    task automatic test_word_store;
        bus.mem_ready = 1'b1;
        drive_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
        step;
        bus.req = 1'b0;
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL ws_mem_en got %b exp 1", bus.mem_en); end
        checks++; if (bus.mem_be !== 4'b1111) begin errors++; $display("FAIL ws_be got %b exp 1111", bus.mem_be); end
        checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL ws_addr got %h exp 10", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ws_wdata got %h exp deadbeef", bus.mem_wdata); end
        checks++; if (bus.moc !== 1'b0) begin errors++; $display("FAIL ws_moc_early got %b exp 0", bus.moc); end
        step;
        checks++; if ({bus.moc, bus.err, bus.busy} !== 3'b100) begin errors++; $display("FAIL ws_done got moc/err/busy %b exp 100", {bus.moc, bus.err, bus.busy}); end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL ws_rdata got %h exp 0", bus.rdata); end
        step;
        checks++; if (bus.moc !== 1'b0) begin errors++; $display("FAIL ws_moc_drop got %b exp 0", bus.moc); end
    endtask

    task automatic test_byte_load_sext;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h80FF_0000;
        drive_req(1'b1, SZ_BYTE, 1'b1, 32'h13, 32'h0);
        step;
        bus.req = 1'b0;
        checks++; if (bus.mem_be !== 4'b1000) begin errors++; $display("FAIL bl_be got %b exp 1000", bus.mem_be); end
        checks++; if (bus.mem_addr !== 32'h10) begin errors++; $display("FAIL bl_addr got %h exp 10", bus.mem_addr); end
        checks++; if (bus.mem_rw !== 1'b1) begin errors++; $display("FAIL bl_rw got %b exp 1", bus.mem_rw); end
        step;
        step;
        step;
        checks++; if ({bus.moc, bus.busy} !== 2'b01) begin errors++; $display("FAIL bl_wait got moc/busy %b exp 01", {bus.moc, bus.busy}); end
        bus.mem_ready = 1'b1;
        step;
        checks++; if ({bus.moc, bus.err} !== 2'b10) begin errors++; $display("FAIL bl_moc got moc/err %b exp 10", {bus.moc, bus.err}); end
        checks++; if (bus.rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL bl_rdata got %h exp ffffff80", bus.rdata); end
        step;
    endtask

    task automatic test_half_load_zext;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h9ABC_1234;
        drive_req(1'b1, SZ_HALF, 1'b0, 32'h22, 32'h0);
        step;
        bus.req = 1'b0;
        checks++; if (bus.mem_be !== 4'b1100) begin errors++; $display("FAIL hl_be got %b exp 1100", bus.mem_be); end
        step;
        checks++; if (bus.rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL hl_rdata got %h exp 00009abc", bus.rdata); end
        step;
    endtask

    task automatic test_store_lanes;
        bus.mem_ready = 1'b1;
        drive_req(1'b0, SZ_BYTE, 1'b0, 32'h05, 32'h0000_00A5);
        step;
        bus.req = 1'b0;
        checks++; if (bus.mem_be !== 4'b0010) begin errors++; $display("FAIL bs_be got %b exp 0010", bus.mem_be); end
        checks++; if (bus.mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL bs_wdata got %h exp a5a5a5a5", bus.mem_wdata); end
        checks++; if (bus.mem_addr !== 32'h04) begin errors++; $display("FAIL bs_addr got %h exp 4", bus.mem_addr); end
        step;
        checks++; if (bus.rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL bs_rdata got %h exp 00009abc", bus.rdata); end
        step;
        drive_req(1'b0, SZ_HALF, 1'b0, 32'h02, 32'h0000_1234);
        step;
        bus.req = 1'b0;
        checks++; if (bus.mem_be !== 4'b1100) begin errors++; $display("FAIL hs_be got %b exp 1100", bus.mem_be); end
        checks++; if (bus.mem_wdata !== 32'h12341234) begin errors++; $display("FAIL hs_wdata got %h exp 12341234", bus.mem_wdata); end
        step;
        step;
    endtask

    task automatic test_errors;
        logic [1:0]  sz  [3] = '{SZ_WORD, SZ_HALF, 2'b11};
        logic [31:0] adr [3] = '{32'h06, 32'h01, 32'h00};
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, sz[i], 1'b0, adr[i], 32'h0);
            step;
            bus.req = 1'b0;
            checks++; if ({bus.moc, bus.err, bus.busy, bus.mem_en} !== 4'b1110) begin
                errors++; $display("FAIL err%0d got moc/err/busy/mem_en %b exp 1110", i, {bus.moc, bus.err, bus.busy, bus.mem_en});
            end
            checks++; if (bus.rdata !== 32'h0000_9ABC) begin errors++; $display("FAIL err%0d_rdata got %h exp 00009abc", i, bus.rdata); end
            step;
            checks++; if ({bus.moc, bus.err, bus.busy} !== 3'b000) begin
                errors++; $display("FAIL err%0d_idle got moc/err/busy %b exp 000", i, {bus.moc, bus.err, bus.busy});
            end
        end
    endtask

    task automatic test_back_to_back;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1122_3344;
        drive_req(1'b1, SZ_WORD, 1'b0, 32'h40, 32'h0);
        step;
        bus.req = 1'b0;
        step;
        checks++; if (bus.moc !== 1'b1) begin errors++; $display("FAIL bb_moc1 got %b exp 1", bus.moc); end
        checks++; if (bus.rdata !== 32'h1122_3344) begin errors++; $display("FAIL bb_rdata1 got %h exp 11223344", bus.rdata); end
        bus.mem_rdata = 32'h1122_B344;
        drive_req(1'b1, SZ_BYTE, 1'b1, 32'h41, 32'h0);
        step;
        bus.req = 1'b0;
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL bb_mem_en2 got %b exp 1", bus.mem_en); end
        checks++; if (bus.mem_be !== 4'b0010) begin errors++; $display("FAIL bb_be2 got %b exp 0010", bus.mem_be); end
        step;
        checks++; if (bus.rdata !== 32'hFFFF_FFB3) begin errors++; $display("FAIL bb_rdata2 got %h exp ffffffb3", bus.rdata); end
        step;
    endtask

    task automatic test_busy_ignore_and_reset;
        int moc_seen;
        bus.mem_ready = 1'b0;
        drive_req(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h0);
        step;
        drive_req(1'b0, SZ_HALF, 1'b0, 32'h200, 32'h0);
        step;
        bus.req = 1'b0;
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL ig_addr got %h exp 100", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'b1111) begin errors++; $display("FAIL ig_be got %b exp 1111", bus.mem_be); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if ({bus.mem_en, bus.busy, bus.moc} !== 3'b000) begin
            errors++; $display("FAIL ar_ctl got mem_en/busy/moc %b exp 000", {bus.mem_en, bus.busy, bus.moc});
        end
        checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL ar_rdata got %h exp 0", bus.rdata); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr got %h exp 0", bus.mem_addr); end
        step;
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        moc_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step;
            if (bus.moc === 1'b1) moc_seen++;
        end
        checks++; if (moc_seen !== 0) begin errors++; $display("FAIL ar_no_moc got %0d moc cycles exp 0", moc_seen); end
    endtask

    task automatic test_timeout;
`ifdef MEM_IF_TIMEOUT_EN
        int cyc;
        bus.mem_ready = 1'b0;
        drive_req(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0);
        cyc = 0;
        step;
        cyc++;
        bus.req = 1'b0;
        while (bus.moc !== 1'b1 && cyc < 20) begin
            step;
            cyc++;
        end
        checks++; if (cyc !== 5) begin errors++; $display("FAIL to_cycle got %0d exp 5", cyc); end
        checks++; if ({bus.err, bus.mem_en} !== 2'b10) begin errors++; $display("FAIL to_err got err/mem_en %b exp 10", {bus.err, bus.mem_en}); end
        step;
        drive_req(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0);
        step;
        bus.req = 1'b0;
        step;
        step;
        step;
        bus.mem_ready = 1'b1;
        step;
        checks++; if ({bus.moc, bus.err} !== 2'b10) begin errors++; $display("FAIL to_race got moc/err %b exp 10", {bus.moc, bus.err}); end
        step;
`else
        int moc_seen;
        bus.mem_ready = 1'b0;
        drive_req(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h0);
        step;
        bus.req = 1'b0;
        moc_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            if (bus.moc === 1'b1) moc_seen++;
        end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL nt_busy got %b exp 1", bus.busy); end
        checks++; if (moc_seen !== 0) begin errors++; $display("FAIL nt_moc got %0d moc cycles exp 0", moc_seen); end
        reset = 1'b0;
        step;
        reset = 1'b1;
        step;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nt_recover got %b exp 0", bus.busy); end
`endif
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.req       = 1'b0;
        bus.rw        = 1'b0;
        bus.size      = SZ_BYTE;
        bus.sign_ext  = 1'b0;
        bus.addr      = '0;
        bus.wdata     = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        test_reset;
        test_word_store;
        test_byte_load_sext;
        test_half_load_zext;
        test_store_lanes;
        test_errors;
        test_back_to_back;
        test_busy_ignore_and_reset;
        test_timeout;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised multicycle memory-access unit that replaces the fixed 32-bit MAR/MDR/RAM path of the multicycle MIPS datapath.
- It accepts one load/store request from the control unit and registers address (MAR) and write data (MDR).
- It drives a byte-enabled memory port, waits a variable number of cycles for the memory ready signal, and returns aligned, sign- or zero-extended read data with a one-cycle MOC pulse.
- It adds byte/halfword/word sizes, alignment checking and an optional timeout, none of which the previous path supports.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8, minimum 16.
- ADDR_W, 32, byte-address width.
- TIMEOUT, 16, maximum ACCESS cycles before abort; used only when MEM_IF_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe from the control unit; sampled only when busy=0.
- rw  in  1  1=read (load), 0=write (store).
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign_ext  in  1  1=sign-extend loads, 0=zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  store data, right-justified.
- busy  out  1  high in ACCESS and ERR.
- moc  out  1  memory operation complete; one-cycle pulse.
- err  out  1  valid with moc; 1=misaligned, illegal size or timeout.
- rdata  out  DATA_W  MDR contents: extended load result.
- mem_en  out  1  memory cycle active.
- mem_rw  out  1  copy of registered rw.
- mem_addr  out  ADDR_W  MAR with low log2(DATA_W/8) bits zeroed.
- mem_be  out  DATA_W/8  byte enables, little-endian lanes.
- mem_wdata  out  DATA_W  store data replicated into the selected lanes.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the access in this cycle.

Behaviour:
- Reset values: all outputs 0, MAR/MDR 0, state IDLE. Reset asserted mid-access drops mem_en immediately and the access is abandoned; no moc is produced.
- States: IDLE, ACCESS, DONE, ERR.
- IDLE/DONE accept a request: req=1 with busy=0 loads MAR, MDR-write, rw, size and sign_ext.
  - A legal, aligned request goes to ACCESS next cycle.
  - Otherwise the unit goes to ERR.
- Alignment rules: halfword requires addr[0]=0; word requires addr[1:0]=0. Size 11 is always an error.
- ACCESS:
  - mem_en=1; mem_be, mem_addr and mem_wdata are stable for the whole access.
  - mem_ready=1 goes to DONE; on a read, mem_rdata is steered and extended into MDR on that edge.
- DONE: moc=1, err=0 for exactly one cycle. A new req in DONE is accepted, giving back-to-back operation; otherwise the unit returns to IDLE.
- ERR: moc=1, err=1 for one cycle, then IDLE. mem_en stays 0 and MDR is unchanged.
- Latency: req at edge N with mem_ready already high gives moc in cycle N+2. Each wait cycle adds 1.
- Byte enables: lane k is enabled for a byte at offset k; a halfword enables lanes k and k+1. For DATA_W>32 a word enables 4 lanes at the word offset.
- Load extension: a byte fills bits DATA_W-1:8 with bit 7 (sign_ext=1) or with 0. A halfword extends from bit 15.
- rdata changes only on completed reads; writes and errors leave it unchanged.
- req while busy=1 is ignored; no queueing.

Optional Feature:
- Macro MEM_IF_TIMEOUT_EN. When defined, a cycle counter clears on ACCESS entry.
  - If mem_ready has not been seen after TIMEOUT cycles in ACCESS, the unit drops mem_en and goes to ERR, giving moc=1, err=1.
  - mem_ready arriving in the same cycle the count expires wins, and the access completes normally.
- When the macro is not defined, there is no counter and ACCESS waits indefinitely.

Decomposition:
- Package mem_if_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encodings;
  - a byte-enable function (size, offset), and an alignment check function.
- Sub-module mem_lane_align: combinational write replication and read steering plus sign/zero extension, instantiated once.
- The FSM, MAR/MDR registers and the timeout counter stay in the top.

Test Plan:
- Word store: addr=0x10, wdata=0xDEADBEEF, mem_ready high → mem_be=1111, mem_addr=0x10; moc 2 cycles after req, err=0.
- Byte load with sign_ext=1: addr=0x13, mem_rdata=0x80FF_0000, 3 wait cycles → mem_be=1000, rdata=0xFFFFFF80, moc at cycle 5.
- Halfword load with sign_ext=0: addr=0x22, mem_rdata=0x9ABC_1234 → rdata=0x00009ABC.
- Misaligned word at addr=0x06 → mem_en never asserted; moc=1, err=1 one cycle after req; rdata unchanged.
- Back-to-back: second req accepted in DONE, mem_en rises the next cycle; reset pulled low during ACCESS → all outputs 0 asynchronously, no moc.
- With MEM_IF_TIMEOUT_EN and TIMEOUT=4, mem_ready held 0 → err=1 moc after 4 ACCESS cycles; without the macro, busy stays high.
